// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared state encoding and widths for the UART TX scheduler.
package uart_tx_scheduler_pkg;
  localparam int GRANT_W = 3;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    ACK       = 3'd3,
    RECOVER   = 3'd4
  } state_e;
endpackage

// File: rtl/uart_tx_scheduler_sync.sv
// uart_tx_scheduler_sync: multi-flop synchroniser for single-bit tx_clock-domain status.
module uart_tx_scheduler_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else r_chain <= {r_chain[STAGES-2:0], i_d};
  end
  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter between byte sources.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      main_clock,
  input  logic                      reset_all,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_free,
  input  logic                      tx_done
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  function automatic logic [GRANT_W-1:0] f_pick(input logic [NUM_REQ-1:0] r, input logic [GRANT_W-1:0] last);
    logic [GRANT_W-1:0] p;
    logic [NUM_REQ-1:0] sh;
    int idx;
    p = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      sh = r >> idx;
      if (sh[0]) p = GRANT_W'(idx);
    end
    return p;
  endfunction
  state_e r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [GRANT_W-1:0] r_grant, r_last, w_pick;
  logic [DATA_W-1:0] r_tx_data;
  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ*DATA_W-1:0] w_bytes;
  logic r_tx_start, r_err, r_free_d, r_done_d;
  logic w_free_s, w_done_s, w_free_r, w_done_r, w_timeout;
  uart_tx_scheduler_sync #(.STAGES(SYNC_STAGES)) u_sync_free (
    .i_clk(main_clock), .i_rst_n(reset_all), .i_d(tx_free), .o_q(w_free_s)
  );
  uart_tx_scheduler_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
    .i_clk(main_clock), .i_rst_n(reset_all), .i_d(tx_done), .o_q(w_done_s)
  );
  assign w_free_r = w_free_s & ~r_free_d;
  assign w_done_r = w_done_s & ~r_done_d;
  assign w_pick   = f_pick(req, r_last);
  assign w_bytes  = req_data >> (int'(w_pick) * DATA_W);
  always_comb begin
    w_timeout = (r_state == START || r_state == WAIT_DONE) && r_timer == TW'(TIMEOUT_CYC - 1);
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = (|req && w_free_s) ? START : IDLE;
      START:     w_next = w_timeout ? RECOVER : (!w_free_s ? WAIT_DONE : START);
      WAIT_DONE: w_next = w_timeout ? RECOVER : ((w_done_r || w_free_r) ? ACK : WAIT_DONE);
      ACK:       w_next = IDLE;
      RECOVER:   w_next = w_free_s ? IDLE : RECOVER;
      default:   w_next = IDLE;
    endcase
  end
  // tx_start follows the START state one cycle late so it drops the cycle the FSM leaves START
  always_ff @(posedge main_clock or negedge reset_all) begin
    if (!reset_all) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_grant    <= '0;
      r_last     <= GRANT_W'(NUM_REQ - 1);
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_free_d   <= 1'b0;
      r_done_d   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_timer    <= (w_next != r_state) ? '0 : ((r_state == START || r_state == WAIT_DONE) ? r_timer + 1'b1 : r_timer);
      r_tx_start <= r_state == START && w_next == START;
      r_ack      <= (w_next == ACK) ? NUM_REQ'(1) << r_grant : '0;
      r_err      <= w_timeout;
      r_free_d   <= w_free_s;
      r_done_d   <= w_done_s;
      if (r_state == IDLE && w_next == START) begin
        r_tx_data <= w_bytes[DATA_W-1:0];
        r_grant   <= w_pick;
      end
      if (r_state == ACK) r_last <= r_grant;
    end
  end
  assign ack      = r_ack;
  assign err      = r_err;
  assign grant_id = r_grant;
  assign busy     = r_state != IDLE;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench with a behavioural transmitter on a main_clock/16 tick.
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req = '0;
  logic [15:0] req_data = '0;
  logic [1:0] ack;
  logic err, busy, tx_start, tx_free, tx_done;
  logic [2:0] grant_id;
  logic [7:0] tx_data;
  logic [1:0] req2 = '0;
  logic [15:0] req_data2 = '0;
  logic [1:0] ack2;
  logic err2, busy2, tx_start2;
  logic [2:0] grant_id2;
  logic [7:0] tx_data2;
  logic free2 = 1'b1;
  logic done2 = 1'b0;
  uart_tx_scheduler #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYC(1024), .SYNC_STAGES(2)) u_dut (
    .main_clock(clk), .reset_all(rst_n), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .grant_id(grant_id), .busy(busy), .tx_data(tx_data), .tx_start(tx_start), .tx_free(tx_free), .tx_done(tx_done)
  );
  uart_tx_scheduler #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT_CYC(64), .SYNC_STAGES(2)) u_dut_to (
    .main_clock(clk), .reset_all(rst_n), .req(req2), .req_data(req_data2), .ack(ack2), .err(err2),
    .grant_id(grant_id2), .busy(busy2), .tx_data(tx_data2), .tx_start(tx_start2), .tx_free(free2), .tx_done(done2)
  );
  logic [7:0] exp_byte_q[$], sent_q[$];
  logic [1:0] exp_ack_q[$], ack_q[$];
  int n_chk = 0, n_pass = 0;
  logic [3:0] div;
  logic m_free, m_done, m_busy;
  logic hold = 1'b0;
  int m_cnt;
  // transmitter model: one tx_clock tick every 16 main cycles, 10 ticks per byte
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0; m_free <= 1'b1; m_done <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
    end else begin
      div <= div + 4'd1;
      if (div == 4'd15) begin
        if (m_busy) begin
          if (m_cnt == 9) begin m_done <= 1'b1; m_free <= 1'b1; m_busy <= 1'b0; end
          m_cnt <= m_cnt + 1;
        end else begin
          m_done <= 1'b0;
          if (tx_start && !hold) begin
            m_free <= 1'b0; m_busy <= 1'b1; m_cnt <= 0;
            sent_q.push_back(tx_data);
          end
        end
      end
    end
  end
  assign tx_free = m_free & ~hold;
  assign tx_done = m_done;
  int cyc = 0, start_cnt = 0, err_cnt = 0, start2_cnt = 0, err2_cnt = 0, ack2_cnt = 0, start2_cyc = 0, err2_cyc = 0;
  logic ps = 1'b0, ps2 = 1'b0, pb2 = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ack != 2'b00) ack_q.push_back(ack);
    if (err) err_cnt <= err_cnt + 1;
    if (tx_start && !ps) start_cnt <= start_cnt + 1;
    ps <= tx_start;
    if (busy2 && !pb2) start2_cyc <= cyc;
    pb2 <= busy2;
    if (err2) begin err2_cnt <= err2_cnt + 1; err2_cyc <= cyc; end
    if (tx_start2 && !ps2) start2_cnt <= start2_cnt + 1;
    ps2 <= tx_start2;
    if (ack2 != 2'b00) ack2_cnt <= ack2_cnt + 1;
  end
  task automatic wait_acks(input int n, input int budget, output int got);
    for (int i = 0; i < budget && ack_q.size() < n; i++) begin
      @(negedge clk); #1;
    end
    got = ack_q.size();
  endtask
  task automatic test_reset;
    #2;
    n_chk++; if ({ack, err, tx_start} !== 4'b0) $display("FAIL reset_pulses got=%b want=0000", {ack, err, tx_start}); else n_pass++;
    n_chk++; if ({grant_id, busy} !== 4'b0) $display("FAIL reset_state got=%b want=0000", {grant_id, busy}); else n_pass++;
    n_chk++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h want=00", tx_data); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_rotation;
    int got;
    logic [7:0] b;
    logic [1:0] a;
    req_data = {8'h22, 8'h11};
    req = 2'b11;
    exp_byte_q = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_ack_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    wait_acks(4, 3000, got);
    req = 2'b00;
    n_chk++; if (got !== 4) $display("FAIL rot_ack_count got=%0d want=4", got); else n_pass++;
    repeat (10) @(negedge clk);
    while (exp_ack_q.size() > 0) begin
      a = ack_q.size() > 0 ? ack_q.pop_front() : 2'bxx;
      n_chk++; if (a !== exp_ack_q[0]) $display("FAIL rot_ack got=%b want=%b", a, exp_ack_q[0]); else n_pass++;
      void'(exp_ack_q.pop_front());
    end
    while (exp_byte_q.size() > 0) begin
      b = sent_q.size() > 0 ? sent_q.pop_front() : 8'hxx;
      n_chk++; if (b !== exp_byte_q[0]) $display("FAIL rot_byte got=%h want=%h", b, exp_byte_q[0]); else n_pass++;
      void'(exp_byte_q.pop_front());
    end
    n_chk++; if (err_cnt !== 0) $display("FAIL rot_err got=%0d want=0", err_cnt); else n_pass++;
  endtask
  task automatic test_single;
    int got, s0;
    logic [7:0] b;
    logic [1:0] a;
    s0 = start_cnt;
    req_data = {8'h00, 8'hA5};
    req = 2'b01;
    exp_byte_q.push_back(8'hA5);
    exp_ack_q.push_back(2'b01);
    wait_acks(1, 1000, got);
    req = 2'b00;
    repeat (10) @(negedge clk);
    a = ack_q.size() > 0 ? ack_q.pop_front() : 2'bxx;
    n_chk++; if (a !== exp_ack_q.pop_front()) $display("FAIL single_ack got=%b want=01", a); else n_pass++;
    b = sent_q.size() > 0 ? sent_q.pop_front() : 8'hxx;
    n_chk++; if (b !== exp_byte_q.pop_front()) $display("FAIL single_byte got=%h want=a5", b); else n_pass++;
    n_chk++; if (ack_q.size() !== 0) $display("FAIL single_ack_width extra=%0d want=0", ack_q.size()); else n_pass++;
    n_chk++; if (start_cnt - s0 !== 1) $display("FAIL single_start_episodes got=%0d want=1", start_cnt - s0); else n_pass++;
    n_chk++; if ({tx_data, grant_id} !== {8'hA5, 3'd0}) $display("FAIL single_latched got=%h/%0d want=a5/0", tx_data, grant_id); else n_pass++;
  endtask
  task automatic test_drop;
    int got, s0;
    logic [7:0] b;
    logic [1:0] a;
    s0 = start_cnt;
    req_data = {8'h00, 8'hC3};
    req = 2'b01;
    exp_byte_q.push_back(8'hC3);
    exp_ack_q.push_back(2'b01);
    for (int i = 0; i < 200 && !m_busy; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    req = 2'b00;
    req_data = {8'h00, 8'hFF};
    repeat (2) @(negedge clk);
    n_chk++; if (tx_data !== 8'hC3) $display("FAIL drop_latched got=%h want=c3", tx_data); else n_pass++;
    wait_acks(1, 1000, got);
    repeat (300) @(negedge clk);
    a = ack_q.size() > 0 ? ack_q.pop_front() : 2'bxx;
    n_chk++; if (a !== exp_ack_q.pop_front()) $display("FAIL drop_ack got=%b want=01", a); else n_pass++;
    b = sent_q.size() > 0 ? sent_q.pop_front() : 8'hxx;
    n_chk++; if (b !== exp_byte_q.pop_front()) $display("FAIL drop_byte got=%h want=c3", b); else n_pass++;
    n_chk++; if ({ack_q.size(), start_cnt - s0} !== {32'd0, 32'd1}) $display("FAIL drop_regrant acks=%0d starts=%0d want=0/1", ack_q.size(), start_cnt - s0); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL drop_idle got=%b want=0", busy); else n_pass++;
  endtask
  task automatic test_hold;
    int got, s0;
    logic [7:0] b;
    logic [1:0] a;
    hold = 1'b1;
    repeat (4) @(negedge clk);
    s0 = start_cnt;
    req_data = {8'h00, 8'h5A};
    req = 2'b01;
    repeat (100) @(negedge clk);
    n_chk++; if ({busy, tx_start, start_cnt - s0} !== {1'b0, 1'b0, 32'd0}) $display("FAIL hold_no_grant busy=%b start=%b episodes=%0d want=0/0/0", busy, tx_start, start_cnt - s0); else n_pass++;
    hold = 1'b0;
    exp_byte_q.push_back(8'h5A);
    exp_ack_q.push_back(2'b01);
    wait_acks(1, 1000, got);
    req = 2'b00;
    repeat (10) @(negedge clk);
    a = ack_q.size() > 0 ? ack_q.pop_front() : 2'bxx;
    n_chk++; if (a !== exp_ack_q.pop_front()) $display("FAIL hold_ack got=%b want=01", a); else n_pass++;
    b = sent_q.size() > 0 ? sent_q.pop_front() : 8'hxx;
    n_chk++; if (b !== exp_byte_q.pop_front()) $display("FAIL hold_byte got=%h want=5a", b); else n_pass++;
    n_chk++; if (start_cnt - s0 !== 1) $display("FAIL hold_episodes got=%0d want=1", start_cnt - s0); else n_pass++;
  endtask
  task automatic test_timeout;
    req_data2 = {8'h00, 8'h99};
    req2 = 2'b01;
    for (int i = 0; i < 500 && err2_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    req2 = 2'b00;
    n_chk++; if (err2_cnt == 0) $display("FAIL to_err_seen got=0 want=1"); else n_pass++;
    n_chk++; if (err2_cyc - start2_cyc !== 64) $display("FAIL to_latency got=%0d want=64", err2_cyc - start2_cyc); else n_pass++;
    repeat (6) @(negedge clk);
    n_chk++; if (err2_cnt !== 1) $display("FAIL to_err_width got=%0d want=1", err2_cnt); else n_pass++;
    n_chk++; if (ack2_cnt !== 0) $display("FAIL to_no_ack got=%0d want=0", ack2_cnt); else n_pass++;
    n_chk++; if ({busy2, tx_start2} !== 2'b00) $display("FAIL to_back_idle got=%b want=00", {busy2, tx_start2}); else n_pass++;
    n_chk++; if (start2_cnt !== 1) $display("FAIL to_start_episodes got=%0d want=1", start2_cnt); else n_pass++;
  endtask
  task automatic test_reset_mid;
    int got;
    logic [7:0] b;
    logic [1:0] a;
    req_data = {8'h00, 8'h77};
    req = 2'b01;
    exp_byte_q.push_back(8'h77);
    for (int i = 0; i < 200 && !m_busy; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    n_chk++; if ({busy, tx_start} !== 2'b10) $display("FAIL mid_in_wait got=%b want=10", {busy, tx_start}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, tx_start, ack, grant_id, tx_data} !== 15'd0) $display("FAIL mid_async_reset got=%h want=0", {busy, tx_start, ack, grant_id, tx_data}); else n_pass++;
    req = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    b = sent_q.size() > 0 ? sent_q.pop_front() : 8'hxx;
    n_chk++; if (b !== exp_byte_q.pop_front()) $display("FAIL mid_byte got=%h want=77", b); else n_pass++;
    n_chk++; if (ack_q.size() !== 0) $display("FAIL mid_no_ack got=%0d want=0", ack_q.size()); else n_pass++;
    req_data = {8'h3C, 8'h00};
    req = 2'b10;
    exp_byte_q.push_back(8'h3C);
    exp_ack_q.push_back(2'b10);
    wait_acks(1, 1000, got);
    req = 2'b00;
    repeat (10) @(negedge clk);
    a = ack_q.size() > 0 ? ack_q.pop_front() : 2'bxx;
    n_chk++; if (a !== exp_ack_q.pop_front()) $display("FAIL mid_ack got=%b want=10", a); else n_pass++;
    b = sent_q.size() > 0 ? sent_q.pop_front() : 8'hxx;
    n_chk++; if (b !== exp_byte_q.pop_front()) $display("FAIL mid_byte2 got=%h want=3c", b); else n_pass++;
    n_chk++; if (grant_id !== 3'd1) $display("FAIL mid_grant got=%0d want=1", grant_id); else n_pass++;
  endtask
  initial begin
    test_reset;
    test_rotation;
    test_single;
    test_drop;
    test_hold;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
